// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: execute->memory bundle, load/store funct3 encodings and the
// memory-stage FSM state enum.
package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] opr_res;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_rd;
    logic        mem_wr;
    logic        rf_en;
    logic [1:0]  wb_sel;
  } mem_stage_in_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: bundle handed from the memory stage to writeback.
//   opr_res    : ALU result / access address
//   dmem_rdata : formatted load data (0 for non-load instructions)
//   rd         : destination register
//   rf_en      : register-file write enable
//   wb_sel     : writeback source select
package wb_stage_pkg;

  typedef struct packed {
    logic [31:0] opr_res;
    logic [31:0] dmem_rdata;
    logic [4:0]  rd;
    logic        rf_en;
    logic [1:0]  wb_sel;
  } wb_stage_in_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for data memory accesses.
//   funct3    in  : access size / signedness
//   is_load   in  : 1 = load (byte enables forced to all lanes)
//   addr_lo   in  : address bits [1:0]
//   rs2_data  in  : store data
//   rdata     in  : aligned word returned by memory
//   be        out : byte enables
//   wdata     out : lane-replicated store data
//   load_data out : extracted and sign/zero-extended load data
// Misaligned halfwords use addr_lo[1] only; words ignore addr_lo.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_load,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'h0, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase

    case (funct3[1:0])
      2'b00: begin
        wdata = {4{rs2_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata = {2{rs2_data[15:0]}};
        be    = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        wdata = rs2_data;
        be    = 4'hF;
      end
    endcase

    if (is_load) be = 4'hF;
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline.
// Issues loads/stores over a req/gnt/rvalid handshake, stalls upstream while an
// access is outstanding, and registers the writeback bundle.
//   clk, rst                         : clock, synchronous active-high reset
//   mem_in_valid, mem_in             : instruction from execute
//   mem_stall                        : upstream must hold mem_in while high
//   dmem_req/we/addr/be/wdata        : data-memory request
//   dmem_gnt, dmem_rvalid, dmem_rdata: data-memory grant and response
//   wb_valid, wb_out                 : registered writeback bundle
//   misalign_exc, misalign_addr      : misalignment trap (MEM_MISALIGN_TRAP_EN)
// Build option MEM_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// accesses are not issued and instead complete immediately with a trap pulse.
//
// state   | meaning
// ST_IDLE | ready for a new instruction; memory ops request combinationally
// ST_REQ  | request outstanding, waiting for dmem_gnt
// ST_RESP | load granted, waiting for dmem_rvalid
module mem_stage
  import mem_stage_pkg::*;
  import wb_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_in_valid,
  input  mem_stage_in_t mem_in,
  output logic          mem_stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [31:0]   dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [31:0]   dmem_rdata,
  output logic          wb_valid,
  output wb_stage_in_t  wb_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic          misalign_exc,
  output logic [31:0]   misalign_addr
`endif
);

  mem_state_e   state_q, state_d;
  logic         mem_op;
  logic         is_load;
  logic         misalign;
  logic         complete;
  logic         load_cap;
  logic [31:0]  load_data;
  wb_stage_in_t wb_d;

  assign mem_op  = mem_in_valid & (mem_in.mem_rd | mem_in.mem_wr);
  assign is_load = mem_in.mem_rd;

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      case (mem_in.funct3[1:0])
        2'b01:   misalign = mem_in.opr_res[0];
        2'b10:   misalign = |mem_in.opr_res[1:0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  lsu_align u_lsu_align (
    .funct3    (mem_in.funct3),
    .is_load   (is_load),
    .addr_lo   (mem_in.opr_res[1:0]),
    .rs2_data  (mem_in.rs2_data),
    .rdata     (dmem_rdata),
    .be        (dmem_be),
    .wdata     (dmem_wdata),
    .load_data (load_data)
  );

  // Upstream holds mem_in stable during a stall, so address/data can be
  // driven straight from it in every state.
  assign dmem_addr = {mem_in.opr_res[31:2], 2'b00};
  assign dmem_we   = mem_in.mem_wr & ~is_load;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    complete = 1'b0;
    load_cap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_in_valid) begin
          if (!mem_op || misalign) begin
            complete = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (dmem_gnt) begin
              if (is_load) state_d  = ST_RESP;
              else         complete = 1'b1;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          if (is_load) begin
            state_d = ST_RESP;
          end else begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
          load_cap = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A request must not escape while the stage is being reset.
    if (rst) dmem_req = 1'b0;
    mem_stall = ~complete & (mem_op | (state_q != ST_IDLE));
  end

  always_comb begin
    wb_d.opr_res    = mem_in.opr_res;
    wb_d.dmem_rdata = load_cap ? load_data : 32'h0;
    wb_d.rd         = mem_in.rd;
    wb_d.rf_en      = mem_in.rf_en & ~misalign;
    wb_d.wb_sel     = mem_in.wb_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_out   <= '0;
    end else begin
      wb_valid <= complete;
      if (complete) wb_out <= wb_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_exc  <= 1'b0;
      misalign_addr <= 32'h0;
    end else begin
      misalign_exc <= complete & misalign;
      if (complete & misalign) misalign_addr <= mem_in.opr_res;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;
  import wb_stage_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_in_valid;
  mem_stage_in_t mem_in;
  logic          mem_stall;
  logic          dmem_req;
  logic          dmem_we;
  logic [31:0]   dmem_addr;
  logic [3:0]    dmem_be;
  logic [31:0]   dmem_wdata;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [31:0]   dmem_rdata;
  logic          wb_valid;
  wb_stage_in_t  wb_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic          misalign_exc;
  logic [31:0]   misalign_addr;
`endif

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .mem_in_valid (mem_in_valid),
    .mem_in       (mem_in),
    .mem_stall    (mem_stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_out       (wb_out)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_exc (misalign_exc),
    .misalign_addr(misalign_addr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] opr_res;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rf_en;
    logic [1:0]  wb_sel;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model -------------------------------------------------------
  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01) return a[0];
    if (f3[1:0] == 2'b10) return (a[1:0] != 2'b00);
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [31:0] v;
    byte         sb;
    shortint     sh;
    case (f3)
      LB, LBU: v = word >> (8 * a[1:0]);
      LH, LHU: v = word >> (16 * a[1]);
      default: v = word;
    endcase
    sb = v[7:0];
    sh = v[15:0];
    case (f3)
      LB:      return 32'(int'(sb));
      LBU:     return v & 32'h0000_00FF;
      LH:      return 32'(int'(sh));
      LHU:     return v & 32'h0000_FFFF;
      default: return v;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    if (ld) return 4'hF;
    case (f3)
      SB:      return 4'(1 << a[1:0]);
      SH:      return 4'(3 << (2 * a[1]));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      SB:      return {24'h0, rs2[7:0]} * 32'h0101_0101;
      SH:      return {16'h0, rs2[15:0]} * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  // Monitor: pops one expectation per wb_valid ---------------------------
  exp_t mon_e;
  logic mon_exc;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exc = 1'b0;
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", wb_valid, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_exc = mon_e.exc;
          check("wb_opr_res", wb_out.opr_res, mon_e.opr_res);
          check("wb_rdata", wb_out.dmem_rdata, mon_e.rdata);
          check("wb_rd", wb_out.rd, mon_e.rd);
          check("wb_rf_en", wb_out.rf_en, mon_e.rf_en);
          check("wb_sel", wb_out.wb_sel, mon_e.wb_sel);
`ifdef MEM_MISALIGN_TRAP_EN
          if (mon_e.exc) check("misalign_addr", misalign_addr, mon_e.opr_res);
`endif
        end
      end
`ifdef MEM_MISALIGN_TRAP_EN
      check("misalign_exc", misalign_exc, mon_exc);
`endif
    end
  end

  // Stimulus: one instruction with a chosen memory latency ---------------
  // kind: 0 = ALU op, 1 = store, 2 = load
  task automatic run_txn(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] word, input logic [4:0] rd,
                         input int gd, input int rdl);
    mem_stage_in_t t;
    exp_t e;
    bit ld, st, trap, done, real_rv;
    int cyc, gcyc, stalls, exp_stalls;
    ld = (kind == 2);
    st = (kind == 1);
    t.opr_res  = addr;
    t.rs2_data = rs2;
    t.rd       = rd;
    t.funct3   = f3;
    t.mem_rd   = ld;
    t.mem_wr   = st;
    t.rf_en    = 1'($urandom);
    t.wb_sel   = 2'($urandom);
    trap = (ld || st) && model_misaligned(f3, addr);
    e.opr_res = addr;
    e.rdata   = (ld && !trap) ? model_load(f3, addr, word) : 32'h0;
    e.rd      = rd;
    e.rf_en   = t.rf_en & ~trap;
    e.wb_sel  = t.wb_sel;
    e.exc     = trap;
    if (!(ld || st) || trap) exp_stalls = 0;
    else if (st)             exp_stalls = gd;
    else                     exp_stalls = gd + rdl;

    mem_in = t;
    mem_in_valid = 1'b1;
    cyc = 0; gcyc = -1; stalls = 0; done = 0;
    while (!done && cyc < 64) begin
      dmem_gnt = (ld || st) && !trap && (gcyc < 0) && (cyc == gd);
      if (dmem_gnt) gcyc = cyc;
      real_rv = ld && !trap && (gcyc >= 0) && (cyc == gcyc + rdl);
      if (real_rv) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = word;
      end else begin
        // Spurious rvalid while no load response is pending must be ignored.
        dmem_rvalid = (gcyc < 0 && !dmem_gnt) ? 1'($urandom) : 1'b0;
        dmem_rdata  = $urandom;
      end
      @(negedge clk);
      if (mem_stall) stalls++;
      check("dmem_req", dmem_req, 32'((ld || st) && !trap && (gcyc < 0 || gcyc == cyc)));
      if (dmem_gnt) begin
        check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
        check("dmem_be", dmem_be, model_be(ld, f3, addr));
        check("dmem_we", dmem_we, 32'(st));
        if (st) check("dmem_wdata", dmem_wdata, model_wdata(f3, rs2));
      end
      done = !(ld || st) || trap || (st && dmem_gnt) || real_rv;
      if (done) exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("txn_done", 32'(done), 32'd1);
    mem_in_valid = 1'b0;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    check("stall_cycles", stalls, exp_stalls);
  endtask

  initial begin
    int kind, gap;
    logic [2:0] f3;
    logic [2:0] ld_ops [5];
    logic [2:0] st_ops [3];
    ld_ops = '{LB, LH, LW, LBU, LHU};
    st_ops = '{SB, SH, SW};

    rst = 1'b1;
    mem_in_valid = 1'b0;
    mem_in = '0;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", wb_valid, 32'd0);
    check("rst_wb_out", wb_out.opr_res | wb_out.dmem_rdata, 32'd0);
    check("rst_dmem_req", dmem_req, 32'd0);
    check("rst_stall", mem_stall, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("rst_misalign_exc", misalign_exc, 32'd0);
    check("rst_misalign_addr", misalign_addr, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;

    run_txn(0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0, 1);
    run_txn(1, SB, 32'h0000_0102, 32'h0000_00AB, 32'h0, 5'd0, 0, 1);
    run_txn(2, LB, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd7, 2, 3);
    run_txn(2, LBU, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd8, 2, 3);
    run_txn(2, LH, 32'h0000_0102, 32'h0, 32'h8001_0000, 5'd9, 1, 1);
    run_txn(2, LHU, 32'h0000_0102, 32'h0, 32'h8001_0000, 5'd10, 0, 2);
    run_txn(1, SH, 32'h0000_0202, 32'h1234_BEEF, 32'h0, 5'd0, 3, 1);
    run_txn(1, SW, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 5'd0, 1, 1);
    run_txn(2, LW, 32'h0000_2001, 32'h0, 32'hDEAD_BEEF, 5'd11, 1, 2);
    run_txn(1, SH, 32'h0000_2003, 32'h0000_5A5A, 32'h0, 5'd0, 0, 1);

    // Reset while a load waits for its response.
    mem_in.opr_res = 32'h0000_0040;
    mem_in.funct3  = LW;
    mem_in.mem_rd  = 1'b1;
    mem_in.mem_wr  = 1'b0;
    mem_in_valid   = 1'b1;
    dmem_gnt       = 1'b1;
    @(negedge clk);
    check("rr_issue_req", dmem_req, 32'd1);
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("rr_resp_stall", mem_stall, 32'd1);
    rst = 1'b1;
    mem_in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rr_req_after", dmem_req, 32'd0);
    check("rr_wb_valid_after", wb_valid, 32'd0);
    check("rr_stall_after", mem_stall, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("rr_late_rvalid", wb_valid, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 2)      f3 = ld_ops[$urandom_range(0, 4)];
      else if (kind == 1) f3 = st_ops[$urandom_range(0, 2)];
      else                f3 = 3'($urandom);
      run_txn(kind, f3, $urandom, $urandom, $urandom, 5'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        dmem_rvalid = 1'($urandom);
        @(posedge clk);
        #1;
      end
      dmem_rvalid = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
